jtcop_obj_dma: RTL and testbench
================================

JTCOP_OBJ_DMA -- requirements
Module: jtcop_obj_dma

Interface
REQ-001 SHALL have parameter TBL_AW, default 10, table address width (1024 words).
REQ-002 SHALL have port clk  in  1  system clock; reset rst, asynchronous, active-high.
REQ-003 SHALL have port rst  in  1  asynchronous active-high reset.
REQ-004 SHALL have port LVBL  in  1  vertical blank, active low.
REQ-005 SHALL have port dma_trig  in  1  one-cycle pulse from CPU write to the DMA register.
REQ-006 SHALL have port busrq  out  1  bus request to CPU object RAM.
REQ-007 SHALL have port busak  in  1  bus grant; sampled every clk.
REQ-008 SHALL have port obj_addr  out  10  CPU object RAM word address.
REQ-009 SHALL have port obj_dout  in  16  CPU object RAM data; valid one clk after obj_addr.
REQ-010 SHALL have port dma_busy  out  1  high while a copy is requested or running.
REQ-011 SHALL have port tbl_addr  in  10  sprite-draw table read address.
REQ-012 SHALL have port tbl_dout  out  16  table data; registered, one clk after tbl_addr.

Function
REQ-013 SHALL hold two 1024x16 banks; draw side reads bank "disp", DMA writes bank ~disp.
REQ-014 SHALL implement states IDLE, REQ, COPY, DONE.
REQ-015 IDLE: on dma_trig -> REQ, busrq=1 next clk.
REQ-016 REQ: hold busrq=1; on busak=1 -> COPY with read counter rcnt=0.
REQ-017 COPY: each clk with busak=1 drive obj_addr=rcnt, rcnt+1; write obj_dout into bank ~disp at rcnt-1 one clk later (1-clk read pipeline).
REQ-018 COPY: if busak=0 mid-copy, SHALL freeze rcnt and suppress the write of the clk, resuming the exact word on re-grant; no word skipped or duplicated.
REQ-019 COPY: after word 1023 is written (1025 granted clks from COPY entry) -> DONE; rcnt wraps only to terminate, never restarts at 0 in-copy.
REQ-020 DONE: busrq=0, set flag ready=1, -> IDLE next clk.
REQ-021 dma_busy SHALL equal (state!=IDLE).
REQ-022 dma_trig while busy SHALL set pending; on reaching IDLE with pending=1 SHALL clear pending and enter REQ directly; multiple triggers collapse to one.
REQ-023 On LVBL falling edge (1->0, registered), if ready=1 SHALL toggle disp and clear ready; if ready=0 disp unchanged.
REQ-024 Swap while COPY active SHALL NOT occur for the bank under copy: ready is only set in DONE, so partial copies never displayed.
REQ-025 LVBL falling edge and DONE on same clk: ready set takes effect, swap happens at the next LVBL falling edge (one frame later).
REQ-026 tbl_dout SHALL read bank disp at tbl_addr with exactly one clk latency, unaffected by concurrent DMA writes.
REQ-027 obj_addr SHALL hold its last value outside COPY.

Reset
REQ-028 On rst: state=IDLE, busrq=0, dma_busy=0, pending=0, ready=0, disp=0, rcnt=0, obj_addr=0, tbl_dout=0; bank contents undefined.
REQ-029 rst mid-copy SHALL abort immediately, dropping busrq asynchronously; no swap follows.

Verification
REQ-030 Trigger, busak tied 1, obj RAM word n = n^16'hA5A5 -> busrq rises clk+1, DONE after 1025 granted clks, after next LVBL fall tbl_addr=0x3FF reads 16'hA65A.
REQ-031 busak toggled 0 for 3 clks at rcnt=500 -> all 1024 words correct, copy takes 1028 granted+stalled clks.
REQ-032 Two dma_trig during COPY -> exactly one extra copy, busrq re-asserted one clk after DONE-IDLE.
REQ-033 No trigger across two frames -> disp unchanged, tbl_dout returns previous frame data.
REQ-034 Copy ends same clk as LVBL fall -> swap deferred one frame; draw reads old bank in between.
REQ-035 rst asserted at rcnt=300 -> busrq=0 same cycle, dma_busy=0, disp=0, no swap at next LVBL fall.

Source files
------------

// File: rtl/jtcop_obj_dma_if.sv
// Object RAM bus between the sprite DMA (master) and the CPU-side object RAM (slave).
interface jtcop_obj_dma_if #(
    parameter int AW = 10
);
    logic          busrq;
    logic          busak;
    logic [AW-1:0] obj_addr;
    logic [15:0]   obj_dout;

    modport master (
        output busrq,
        output obj_addr,
        input  busak,
        input  obj_dout
    );

    modport slave (
        input  busrq,
        input  obj_addr,
        output busak,
        output obj_dout
    );
endinterface

// File: rtl/jtcop_obj_dma.sv
// Sprite table DMA: copies CPU object RAM into the hidden half of a double-buffered
// table and swaps the displayed half at the first vblank after a complete copy.
//
// state | meaning
// IDLE  | waiting for dma_trig or a pending request
// REQ   | busrq held, waiting for busak
// COPY  | reading object RAM, writing hidden bank, frozen while busak=0
// DONE  | bus released, hidden bank marked ready for the next vblank
module jtcop_obj_dma #(
    parameter int TBL_AW = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                LVBL,
    input  logic                dma_trig,
    jtcop_obj_dma_if.master     bus,
    output logic                dma_busy,
    input  logic [TBL_AW-1:0]   tbl_addr,
    output logic [15:0]         tbl_dout
);
    localparam int WORDS = 1 << TBL_AW;
    localparam logic [TBL_AW:0] ONE = 1;

    typedef enum logic [1:0] {IDLE, REQ, COPY, DONE} state_t;

    state_t            state;
    logic [TBL_AW:0]   rcnt;
    logic [TBL_AW:0]   rcnt_inc;
    logic [TBL_AW:0]   rcnt_dec;
    logic              pending;
    logic              ready;
    logic              disp;
    logic              lvbl_q;
    logic              lvbl_fall;
    logic              rd_pend;
    logic              hold_vld;
    logic [15:0]       hold_data;
    logic              granted;
    logic              last_word;
    logic              wr_en;
    logic [TBL_AW-1:0] wr_addr;
    logic [15:0]       wr_data;
    logic [15:0]       bank [0:2*WORDS-1];

    assign rcnt_inc  = rcnt + ONE;
    assign rcnt_dec  = rcnt - ONE;
    assign lvbl_fall = lvbl_q & ~LVBL;
    assign granted   = (state == COPY) && bus.busak;
    assign last_word = rcnt[TBL_AW];
    assign wr_en     = granted && (rcnt != '0);
    assign wr_addr   = rcnt_dec[TBL_AW-1:0];
    // A read issued just before a stall is parked in hold_data, since obj_dout
    // belongs to the CPU while the grant is withdrawn.
    assign wr_data   = hold_vld ? hold_data : bus.obj_dout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bus.busrq    <= 1'b0;
            bus.obj_addr <= '0;
            dma_busy     <= 1'b0;
            pending      <= 1'b0;
            ready        <= 1'b0;
            disp         <= 1'b0;
            lvbl_q       <= 1'b0;
            rcnt         <= '0;
            rd_pend      <= 1'b0;
            hold_vld     <= 1'b0;
            hold_data    <= '0;
        end else begin
            lvbl_q <= LVBL;
            if (dma_trig && state != IDLE) pending <= 1'b1;
            // Completion wins over a coincident vblank: the swap waits a frame.
            if (state == DONE) begin
                ready <= 1'b1;
            end else if (lvbl_fall && ready) begin
                disp  <= ~disp;
                ready <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (dma_trig || pending) begin
                        state     <= REQ;
                        bus.busrq <= 1'b1;
                        dma_busy  <= 1'b1;
                        pending   <= 1'b0;
                    end
                end
                REQ: begin
                    if (bus.busak) begin
                        state        <= COPY;
                        rcnt         <= '0;
                        bus.obj_addr <= '0;
                        ready        <= 1'b0;
                        rd_pend      <= 1'b0;
                        hold_vld     <= 1'b0;
                    end
                end
                COPY: begin
                    if (bus.busak) begin
                        hold_vld <= 1'b0;
                        if (last_word) begin
                            state     <= DONE;
                            bus.busrq <= 1'b0;
                            rcnt      <= '0;
                            rd_pend   <= 1'b0;
                        end else begin
                            rcnt         <= rcnt_inc;
                            bus.obj_addr <= rcnt_inc[TBL_AW-1:0];
                            rd_pend      <= 1'b1;
                        end
                    end else begin
                        rd_pend <= 1'b0;
                        if (rd_pend) begin
                            hold_vld  <= 1'b1;
                            hold_data <= bus.obj_dout;
                        end
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    dma_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) bank[{~disp, wr_addr}] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tbl_dout <= '0;
        else     tbl_dout <= bank[{disp, tbl_addr}];
    end
endmodule

// File: tb/tb_jtcop_obj_dma.sv
// Randomized bench for jtcop_obj_dma against a frame-level model of the two banks.
module tb_jtcop_obj_dma;
    logic        clk;
    logic        rst;
    logic        LVBL;
    logic        dma_trig;
    logic        dma_busy;
    logic [9:0]  tbl_addr;
    logic [15:0] tbl_dout;

    jtcop_obj_dma_if #(.AW(10)) bus ();

    jtcop_obj_dma #(.TBL_AW(10)) dut (
        .clk      (clk),
        .rst      (rst),
        .LVBL     (LVBL),
        .dma_trig (dma_trig),
        .bus      (bus),
        .dma_busy (dma_busy),
        .tbl_addr (tbl_addr),
        .tbl_dout (tbl_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // CPU object RAM: registered read; while the bus is not granted the data lines carry junk.
    logic [15:0] obj_mem [0:1023];
    always @(posedge clk) bus.obj_dout <= bus.busak ? obj_mem[bus.obj_addr] : 16'($urandom);

    logic [15:0] mdl_bank [0:1][0:1023];
    int          mdl_disp;
    bit          mdl_ready;
    int          n_total;
    int          n_bad;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < 1024; i++) obj_mem[i] = 16'($urandom);
    endtask

    task automatic mdl_vbl();
        if (mdl_ready) begin
            mdl_disp  = 1 - mdl_disp;
            mdl_ready = 0;
        end
    endtask

    task automatic do_vbl();
        LVBL = 1'b0;
        mdl_vbl();
        @(negedge clk);
        LVBL = 1'b1;
        idle(1);
    endtask

    task automatic rd_chk(input string tag, input int addr);
        tbl_addr = 10'(addr);
        @(negedge clk);
        chk(tag, {16'd0, tbl_dout}, {16'd0, mdl_bank[mdl_disp][addr]});
    endtask

    task automatic rd_some(input string tag, input int n, input int lo);
        for (int i = 0; i < n; i++) rd_chk(tag, $urandom_range(lo, 1023));
        rd_chk(tag, 1023);
    endtask

    // Drives the grant side of one copy. mode: 0 always granted, 1 three-clk stall
    // at rcnt=500, 2 random stalls. Called at a negedge right after any trigger pulse.
    task automatic do_copy(input int mode, input int abort_at, input bit trig_mid,
                           input bit vbl_at_done, output int wait_n, output int hi_n,
                           output int stalls);
        int  grants;
        int  st500;
        bit  give;
        bit  aborted;
        wait_n = 0; hi_n = 0; stalls = 0; grants = 0; st500 = 0; aborted = 0;
        do begin
            @(negedge clk);
            dma_trig = 1'b0;
            wait_n++;
        end while (!bus.busrq && wait_n < 20);
        while (bus.busrq && hi_n < 6000 && !aborted) begin
            hi_n++;
            if (abort_at > 0 && grants == abort_at) begin
                #2 rst = 1'b1;
                #1 chk("rst_busrq", {31'd0, bus.busrq}, 32'd0);
                chk("rst_busy", {31'd0, dma_busy}, 32'd0);
                aborted = 1;
            end else begin
                dma_trig = trig_mid && (grants == 100 || grants == 700);
                case (mode)
                    1: give = !(grants == 501 && st500 < 3);
                    2: give = ($urandom_range(0, 7) != 0);
                    default: give = 1'b1;
                endcase
                if (!give && mode == 1) st500++;
                bus.busak = give;
                if (give) grants++;
                else stalls++;
                @(negedge clk);
            end
        end
        dma_trig  = 1'b0;
        bus.busak = 1'b1;
        if (aborted) return;
        if (vbl_at_done) begin
            LVBL = 1'b0;
            mdl_vbl();
        end
        for (int i = 0; i < 1024; i++) mdl_bank[1 - mdl_disp][i] = obj_mem[i];
        mdl_ready = 1;
        if (vbl_at_done) begin
            @(negedge clk);
            LVBL = 1'b1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int w, h, s;

    initial begin
        n_total = 0; n_bad = 0;
        mdl_disp = 0; mdl_ready = 0;
        rst = 1'b1; LVBL = 1'b1; dma_trig = 1'b0; bus.busak = 1'b1; tbl_addr = '0;
        @(negedge clk);
        chk("rst_busrq0", {31'd0, bus.busrq}, 32'd0);
        chk("rst_busy0", {31'd0, dma_busy}, 32'd0);
        chk("rst_objaddr", {22'd0, bus.obj_addr}, 32'd0);
        chk("rst_tbl", {16'd0, tbl_dout}, 32'd0);
        rst = 1'b0;
        idle(3);

        // basic copy, bus tied granted
        for (int i = 0; i < 1024; i++) obj_mem[i] = 16'(i) ^ 16'hA5A5;
        dma_trig = 1'b1;
        do_copy(0, 0, 0, 0, w, h, s);
        chk("a_busrq_lat", w, 1);
        chk("a_hi_clks", h, 1026);
        chk("a_busy_done", {31'd0, dma_busy}, 32'd1);
        idle(1);
        chk("a_busy_idle", {31'd0, dma_busy}, 32'd0);
        idle(2);
        do_vbl();
        rd_chk("a_rd", 0);
        tbl_addr = 10'h3FF;
        @(negedge clk);
        chk("a_rd_3ff", {16'd0, tbl_dout}, 32'h0000A65A);

        // stall of three clks at rcnt=500, every word checked
        fill_rand();
        dma_trig = 1'b1;
        do_copy(1, 0, 0, 0, w, h, s);
        chk("b_hi_clks", h, 1029);
        idle(3);
        do_vbl();
        for (int i = 0; i < 1024; i++) rd_chk("b_rd", i);

        // two frames with no trigger: display stays put
        do_vbl();
        do_vbl();
        rd_some("c_rd", 8, 0);

        // random stalls in REQ and COPY
        fill_rand();
        dma_trig = 1'b1;
        do_copy(2, 0, 0, 0, w, h, s);
        chk("d_hi_clks", h, 1026 + s);
        idle(3);
        do_vbl();
        rd_some("d_rd", 16, 0);

        // two triggers mid-copy collapse into exactly one extra copy
        fill_rand();
        dma_trig = 1'b1;
        do_copy(0, 0, 1, 0, w, h, s);
        chk("e_hi1", h, 1026);
        fill_rand();
        do_copy(0, 0, 0, 0, w, h, s);
        chk("e_rereq_lat", w, 2);
        chk("e_hi2", h, 1026);
        idle(8);
        chk("e_no_third", {31'd0, bus.busrq}, 32'd0);
        chk("e_busy", {31'd0, dma_busy}, 32'd0);
        do_vbl();
        rd_some("e_rd", 16, 0);

        // completion on the same clk as vblank: swap deferred one frame
        fill_rand();
        dma_trig = 1'b1;
        do_copy(0, 0, 0, 1, w, h, s);
        chk("f_hi_clks", h, 1026);
        idle(2);
        rd_some("f_rd_old", 8, 0);
        do_vbl();
        rd_some("f_rd_new", 8, 0);

        // reset in the middle of a copy
        fill_rand();
        dma_trig = 1'b1;
        do_copy(0, 301, 0, 0, w, h, s);
        @(negedge clk);
        rst = 1'b0;
        mdl_disp = 0;
        mdl_ready = 0;
        rd_some("g_rd_rst", 8, 512);
        do_vbl();
        rd_some("g_rd_noswap", 8, 512);
        chk("g_busrq", {31'd0, bus.busrq}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
